// File: rtl/result_display.sv
// result_display
// ----------------------------------------------------------------------------
// Registered 4-digit seven-segment scan driver for the calculator result.
// A 5-bit signed-magnitude result and its divide-by-zero / zero flags are
// captured on a one-cycle valid strobe and held. Sign, tens and ones digits
// (or "Err") are then time-multiplexed onto a common-anode display. The
// display stays blank until the first result has been captured.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   result     [4] sign (1 = negative), [3:0] magnitude 0..15
//   in_valid   one-cycle strobe: capture result/divbyzero/zero
//   divbyzero  arithmetic error flag, sampled with in_valid
//   zero       result-is-zero flag, sampled with in_valid
//   seg        active-low segments, seg[0]=a .. seg[6]=g
//   an         active-low digit enables, an[3] is the leftmost digit
//   dp         active-low decimal point, held off (1)
// ----------------------------------------------------------------------------
module result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] result,
  input  logic       in_valid,
  input  logic       divbyzero,
  input  logic       zero,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  // Prescaler width; REFRESH_DIV=1 still needs a 1-bit counter that stays 0.
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] PRESC_LAST = CW'(REFRESH_DIV - 1);

  // Internal character codes fed to the segment encoder.
  localparam logic [3:0] CH_DASH  = 4'd10;
  localparam logic [3:0] CH_E     = 4'd11;
  localparam logic [3:0] CH_R     = 4'd12;
  localparam logic [3:0] CH_BLANK = 4'd15;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    SHOW  = 2'd1,
    ERR   = 2'd2
  } mode_e;

  mode_e         mode_r;
  logic [3:0]    hold_mag_r;
  logic          hold_neg_r;
  logic          hold_err_r;
  logic [CW-1:0] presc_r;
  logic [1:0]    idx_r;

  logic [3:0]    ones_s;
  logic [3:0]    char_s;
  logic [6:0]    seg_nxt_s;
  logic [3:0]    an_nxt_s;

  // Character code to active-low gfedcba pattern; unknown codes go blank.
  function automatic logic [6:0] seg_code(input logic [3:0] code);
    case (code)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      4'd10:   seg_code = 7'b0111111;
      4'd11:   seg_code = 7'b0000110;
      4'd12:   seg_code = 7'b0101111;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Mode FSM and held result: every strobe overwrites, reset beats a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_r     <= BLANK;
      hold_mag_r <= 4'd0;
      hold_neg_r <= 1'b0;
      hold_err_r <= 1'b0;
    end else if (in_valid) begin
      hold_mag_r <= result[3:0];
      // Negative zero never shows a sign, whichever flag marks it as zero.
      hold_neg_r <= result[4] & ~zero & (result[3:0] != 4'd0);
      hold_err_r <= divbyzero;
      mode_r     <= divbyzero ? ERR : SHOW;
    end
  end

  // Free-running refresh prescaler and digit index, independent of captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= '0;
      idx_r   <= 2'd0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
      idx_r   <= idx_r + 2'd1;
    end else begin
      presc_r <= presc_r + CW'(1);
    end
  end

  // Ones digit of 0..15 without a divider.
  always_comb begin
    if (hold_mag_r >= 4'd10) begin
      ones_s = hold_mag_r - 4'd10;
    end else begin
      ones_s = hold_mag_r;
    end
  end

  // Character for the currently scanned digit, then its anode and segments.
  always_comb begin
    char_s    = CH_BLANK;
    seg_nxt_s = SEG_BLANK;
    an_nxt_s  = 4'b1111;
    case (mode_r)
      SHOW, ERR: begin
        an_nxt_s = ~(4'b0001 << idx_r);
        // A stray error flag outside ERR is still shown as an error.
        if ((mode_r == ERR) || hold_err_r) begin
          case (idx_r)
            2'd0:    char_s = CH_R;
            2'd1:    char_s = CH_R;
            2'd2:    char_s = CH_E;
            default: char_s = CH_BLANK;
          endcase
        end else begin
          case (idx_r)
            2'd0:    char_s = ones_s;
            2'd1:    char_s = (hold_mag_r >= 4'd10) ? 4'd1 : CH_BLANK;
            2'd2:    char_s = hold_neg_r ? CH_DASH : CH_BLANK;
            default: char_s = CH_BLANK;
          endcase
        end
        seg_nxt_s = seg_code(char_s);
      end
      default: begin
        char_s    = CH_BLANK;
        seg_nxt_s = SEG_BLANK;
        an_nxt_s  = 4'b1111;
      end
    endcase
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an  <= 4'b1111;
      dp  <= 1'b1;
    end else begin
      seg <= seg_nxt_s;
      an  <= an_nxt_s;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Testbench for result_display: a behavioural model checks every cycle,
// a table of results checks one full frame each, and short sequences cover
// reset priority and reset out of the error display.
module tb_result_display;

  localparam int DIV = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] result;
  logic       in_valid;
  logic       divbyzero;
  logic       zero;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: edges since reset, captured mode (0 blank, 1 show, 2 err).
  int         m_n;
  int         m_mode;
  int         m_mag;
  bit         m_neg;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;

  typedef struct {
    logic [4:0] res;
    logic       dbz;
    logic       zr;
    logic [6:0] d0;
    logic [6:0] d1;
    logic [6:0] d2;
  } vec_t;

  vec_t vecs[7];

  result_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .result(result), .in_valid(in_valid),
    .divbyzero(divbyzero), .zero(zero), .seg(seg), .an(an), .dp(dp)
  );

  always #5 clk = ~clk;

  // 0..9 digits, 10 '-', 11 'E', 12 'r', anything else blank.
  function automatic logic [6:0] char_seg(input int c);
    case (c)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0111111; 11: return 7'b0000110;
      12: return 7'b0101111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected outputs for this edge come from the state before it.
  task automatic model_edge();
    int ch[4];
    int idx;
    if (rst) begin
      exp_seg = 7'b1111111;
      exp_an  = 4'b1111;
      m_n = 0; m_mode = 0; m_mag = 0; m_neg = 1'b0;
    end else begin
      idx = (m_n / DIV) % 4;
      if (m_mode == 0) begin
        exp_seg = 7'b1111111;
        exp_an  = 4'b1111;
      end else begin
        if (m_mode == 1) begin
          ch[3] = 13;
          ch[2] = m_neg ? 10 : 13;
          ch[1] = (m_mag >= 10) ? 1 : 13;
          ch[0] = m_mag % 10;
        end else begin
          ch[3] = 13; ch[2] = 11; ch[1] = 12; ch[0] = 12;
        end
        exp_seg = char_seg(ch[idx]);
        exp_an  = 4'b1111;
        exp_an[idx] = 1'b0;
      end
      m_n++;
      if (in_valid) begin
        m_mode = divbyzero ? 2 : 1;
        m_mag  = int'(result[3:0]);
        m_neg  = (result[4] == 1'b1) && !zero && (result[3:0] != 4'd0);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (chk_en) check("scan", {20'd0, seg, an, dp}, {20'd0, exp_seg, exp_an, 1'b1});
  endtask

  task automatic capture(input logic [4:0] r, input logic d, input logic z);
    in_valid = 1'b1; result = r; divbyzero = d; zero = z;
    step();
    in_valid = 1'b0;
    result = 5'($urandom); divbyzero = 1'($urandom); zero = 1'($urandom);
    step();
  endtask

  initial begin
    int cnt[4];
    int k;
    logic [6:0] want;

    vecs[0] = '{5'b0_1101, 1'b0, 1'b0, 7'b0110000, 7'b1111001, 7'b1111111};
    vecs[1] = '{5'b1_0100, 1'b0, 1'b0, 7'b0011001, 7'b1111111, 7'b0111111};
    vecs[2] = '{5'b1_0000, 1'b0, 1'b1, 7'b1000000, 7'b1111111, 7'b1111111};
    vecs[3] = '{5'b0_0110, 1'b1, 1'b0, 7'b0101111, 7'b0101111, 7'b0000110};
    vecs[4] = '{5'b0_0010, 1'b0, 1'b0, 7'b0100100, 7'b1111111, 7'b1111111};
    vecs[5] = '{5'b1_1111, 1'b0, 1'b0, 7'b0010010, 7'b1111001, 7'b0111111};
    vecs[6] = '{5'b0_1010, 1'b0, 1'b0, 7'b1000000, 7'b1111001, 7'b1111111};

    rst = 1'b1; in_valid = 1'b0; result = 5'd0; divbyzero = 1'b0; zero = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("reset_out", {20'd0, seg, an, dp}, {20'd0, 7'b1111111, 4'b1111, 1'b1});

    // Blank before any capture, while the index keeps scanning.
    for (int i = 0; i < 12; i++) begin
      result = 5'($urandom); divbyzero = 1'($urandom); zero = 1'($urandom);
      step();
    end
    check("blank_an", {28'd0, an}, 32'hF);
    check("blank_seg", {25'd0, seg}, 32'h7F);

    // One full frame per table entry; each digit lit exactly DIV cycles.
    foreach (vecs[v]) begin
      capture(vecs[v].res, vecs[v].dbz, vecs[v].zr);
      for (int b = 0; b < 4; b++) cnt[b] = 0;
      for (int c = 0; c < 4 * DIV; c++) begin
        check("onehot_an", $countones(~an), 1);
        k = 0;
        for (int b = 0; b < 4; b++) if (!an[b]) k = b;
        want = (k == 0) ? vecs[v].d0 : (k == 1) ? vecs[v].d1 :
               (k == 2) ? vecs[v].d2 : 7'b1111111;
        check($sformatf("digit%0d_v%0d", k, v), {25'd0, seg}, {25'd0, want});
        cnt[k]++;
        step();
      end
      for (int b = 0; b < 4; b++) check($sformatf("dwell%0d_v%0d", b, v), cnt[b], DIV);
    end

    // Reset wins over a simultaneous strobe.
    capture(5'b0_0101, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; result = 5'b0_0111;
    step();
    rst = 1'b0; in_valid = 1'b0;
    step();
    check("rstprio_an", {28'd0, an}, 32'hF);
    check("rstprio_seg", {25'd0, seg}, 32'h7F);
    check("rstprio_mag", {28'd0, dut.hold_mag_r}, 32'h0);
    for (int i = 0; i < 6; i++) step();

    // Reset out of the error display, then scanning restarts from digit 0.
    capture(5'b0_0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsterr_an", {28'd0, an}, 32'hF);
    capture(5'b0_1001, 1'b0, 1'b0);
    check("restart_idx0", {28'd0, an}, 32'hE);

    // Random traffic, including back-to-back strobes and occasional reset.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = ($urandom_range(0, 3) == 0);
      result    = 5'($urandom);
      divbyzero = ($urandom_range(0, 7) == 0);
      zero      = (result[3:0] == 4'd0) ? 1'b1 : ($urandom_range(0, 7) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_display.md
# result_display

Registered 4-digit seven-segment scan driver. It sits directly downstream of the calculator's arithmetic units (remainder, sum, product). It captures a 5-bit signed-magnitude result and its divide-by-zero/zero flags on a valid strobe, holds them, and time-multiplexes sign, tens and ones digits, or "Err", onto a common-anode display. Output is blank until the first result is captured.

## Interface
- REFRESH_DIV, 50000, clock cycles each digit stays lit; legal range ≥ 1.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- result  input  5  signed-magnitude result: bit 4 = sign (1 = negative), bits 3:0 = magnitude 0..15.
- in_valid  input  1  one-cycle strobe: capture result/divbyzero/zero this edge.
- divbyzero  input  1  arithmetic error flag, sampled with in_valid.
- zero  input  1  result-is-zero flag, sampled with in_valid.
- seg  output  7  active-low segments, seg[0]=a … seg[6]=g.
- an  output  4  active-low digit enables, an[3] leftmost.
- dp  output  1  active-low decimal point, constant 1 (off) after reset.

## Operation
- Held registers: hold_mag[3:0], hold_neg, hold_err. On in_valid, all three load the inputs, and hold_neg = result[4] & ~zero & (result[3:0] != 0). Negative zero never shows a sign. Without in_valid they keep their values.
- Mode FSM states:
  - BLANK (reset state).
  - SHOW.
  - ERR.
- FSM transitions on in_valid, from any state: divbyzero=1 → ERR; else → SHOW. No other transitions except rst → BLANK.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. On the wrap edge, the 2-bit digit index advances 0→1→2→3→0.
- Index i selects an[i]=0 and all other anodes 1. Digit content by state:
  - BLANK: an=4'b1111, seg=7'b1111111 regardless of index.
  - SHOW: digit 3 blank. Digit 2 is '-' if hold_neg, else blank. Digit 1 is '1' if hold_mag ≥ 10, else blank. Digit 0 is hold_mag mod 10.
  - ERR: digit 3 blank, digit 2 'E', digit 1 'r', digit 0 'r'.
- A blank digit still has its anode asserted, with seg=7'b1111111.
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, 'E'=0000110, 'r'=0101111, blank=1111111
- in_valid does not disturb the prescaler or the digit index. Scanning is continuous from reset, including in BLANK.

## Timing
- Reset values, one cycle after rst sampled high: prescaler=0, index=0, state=BLANK, hold_*=0, seg=7'b1111111, an=4'b1111, dp=1.
- seg/an are registered outputs decoded from the current state, index and hold registers. They reflect a capture one cycle after the in_valid edge, so the new value appears at edge N+1 when in_valid is high at edge N.
- Index change at prescaler wrap edge W is visible on an/seg at edge W+1.
- Each index occupies exactly REFRESH_DIV cycles. Full frame = 4·REFRESH_DIV cycles. REFRESH_DIV=1 advances the index every cycle.
- in_valid on consecutive cycles: each edge overwrites; the last capture wins.
- rst and in_valid high together: rst wins, nothing captured.
- rst mid-scan or in ERR: next cycle is fully blank, and the index restarts at 0.
- Inputs other than in_valid are ignored when in_valid=0. Changes on result with no strobe must not alter the display.

## Test plan
- Reset: hold rst 2 cycles, REFRESH_DIV=2 → an=1111, seg=1111111, dp=1 until first in_valid; the index still cycles internally.
- Positive two-digit: in_valid with result=5'b0_1101 (13), divbyzero=0, zero=0 → over one 8-cycle frame: digit0 seg=0110000 ('3'), digit1 '1', digit2 blank, digit3 blank, each an low for exactly 2 cycles.
- Negative one-digit: result=5'b1_0100 (-4) → digit2 '-' (0111111), digit1 blank, digit0 0011001; capture visible one cycle after strobe.
- Negative zero: result=5'b1_0000, zero=1 → digit2 blank, digit0 '0' (1000000).
- Error and recovery: in_valid with divbyzero=1 → digits 2..0 show E,r,r. Next in_valid with result=5'b0_0010 → SHOW '2', without the prescaler resetting.
- Reset priority: rst and in_valid in the same cycle with result=5'b0_0111 → display stays blank, and hold_mag reads 0.
